// File: rtl/button_bank.sv
// Multi-channel push-button conditioner: 2-FF synchroniser plus per-channel debounce FSM.
// Optional auto-repeat while held is enabled by defining BTN_REPEAT_EN.
module button_bank #(
  parameter int N_BTN        = 4,
  parameter int DEB_CYCLES   = 1000,
  parameter int CNT_W        = 16,
  parameter int REPEAT_DELAY = 50000,
  parameter int REPEAT_RATE  = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] b_n,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic             any_press
);

  typedef enum logic [1:0] {IDLE, DEB_P, HELD, DEB_R} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  if (N_BTN < 1 || DEB_CYCLES < 1 || DEB_CYCLES > (1 << CNT_W) ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > (1 << CNT_W) ||
      REPEAT_RATE < 1 || REPEAT_RATE > (1 << CNT_W)) begin : g_param_check
    $error("button_bank: parameter out of range for CNT_W");
  end

  logic [N_BTN-1:0] sync_p0;
  logic [N_BTN-1:0] sync_p1;
  state_t           state [N_BTN];
  logic [CNT_W-1:0] cnt   [N_BTN];

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  // rep_rate selects the inter-repeat period once the first repeat has fired
  logic [CNT_W-1:0] rep_cnt [N_BTN];
  logic [N_BTN-1:0] rep_rate;
`endif

  // Stage p0/p1: synchroniser, idles at released (all ones)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= b_n;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce FSMs: one per channel, driven only by the synchronised level
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
`ifdef BTN_REPEAT_EN
        rep_cnt[i] <= '0;
`endif
      end
`ifdef BTN_REPEAT_EN
      rep_rate <= '0;
`endif
      pressed       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        unique case (state[i])
          IDLE: begin
            if (!sync_p1[i]) begin
              state[i] <= DEB_P;
              cnt[i]   <= '0;
            end
          end
          DEB_P: begin
            if (sync_p1[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == DEB_LAST) begin
              state[i]       <= HELD;
              cnt[i]         <= '0;
              pressed[i]     <= 1'b1;
              press_pulse[i] <= 1'b1;
`ifdef BTN_REPEAT_EN
              rep_cnt[i]  <= '0;
              rep_rate[i] <= 1'b0;
`endif
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          HELD: begin
            if (sync_p1[i]) begin
              state[i] <= DEB_R;
              cnt[i]   <= '0;
            end
`ifdef BTN_REPEAT_EN
            else if (rep_rate[i] ? (rep_cnt[i] == RATE_LAST) : (rep_cnt[i] == DELAY_LAST)) begin
              press_pulse[i] <= 1'b1;
              rep_cnt[i]     <= '0;
              rep_rate[i]    <= 1'b1;
            end else begin
              rep_cnt[i] <= rep_cnt[i] + CNT_W'(1);
            end
`endif
          end
          DEB_R: begin
            if (!sync_p1[i]) begin
              // bounce back to held restarts the auto-repeat delay
              state[i] <= HELD;
              cnt[i]   <= '0;
`ifdef BTN_REPEAT_EN
              rep_cnt[i]  <= '0;
              rep_rate[i] <= 1'b0;
`endif
            end else if (cnt[i] == DEB_LAST) begin
              state[i]         <= IDLE;
              cnt[i]           <= '0;
              pressed[i]       <= 1'b0;
              release_pulse[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign any_press = |press_pulse;

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: stimulus queues expected pulse events,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_button_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] b_n;
  logic [3:0] pressed;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic       any_press;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] pp;
    logic [3:0] rp;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  button_bank #(
    .N_BTN       (4),
    .DEB_CYCLES  (4),
    .CNT_W       (8),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .b_n          (b_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .any_press    (any_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int c, input logic [3:0] pp, input logic [3:0] rp);
    ev_t e;
    e.cyc = c;
    e.pp  = pp;
    e.rp  = rp;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_level(input string name, input logic [3:0] exp);
    checks++;
    if (pressed !== exp) begin
      errors++;
      $display("FAIL %s: pressed=%b expected %b (cycle %0d)", name, pressed, exp, cyc);
    end
  endtask

  // Monitor: flag overdue expectations, then match any strobe against the queue head
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event: nothing seen, expected pp=%b rp=%b at cycle %0d",
               mon_e.pp, mon_e.rp, mon_e.cyc);
    end
    if ((press_pulse | release_pulse) != 4'b0000 || any_press) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: pp=%b rp=%b any=%b at cycle %0d, expected none",
                 press_pulse, release_pulse, any_press, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || press_pulse !== mon_e.pp || release_pulse !== mon_e.rp ||
            any_press !== (|mon_e.pp)) begin
          errors++;
          $display("FAIL event: got pp=%b rp=%b any=%b at cycle %0d, expected pp=%b rp=%b any=%b at cycle %0d",
                   press_pulse, release_pulse, any_press, cyc,
                   mon_e.pp, mon_e.rp, |mon_e.pp, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    int a;
    rst = 1'b1;
    b_n = 4'b0000;

    // Reset held with all buttons down: outputs quiet, then a fresh press on all
    tick(3);
    checks++;
    if ({pressed, press_pulse, release_pulse, any_press} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got pressed=%b pp=%b rp=%b any=%b, expected all 0",
               pressed, press_pulse, release_pulse, any_press);
    end
    expect_ev(cyc + 7, 4'b1111, 4'b0000);
    rst = 1'b0;
    tick(8);
    check_level("t1_held", 4'b1111);
    b_n = 4'b1111;
    expect_ev(cyc + 7, 4'b0000, 4'b1111);
    tick(10);
    check_level("t1_released", 4'b0000);

    // Clean press and release on channel 0
    b_n[0] = 1'b0;
    expect_ev(cyc + 7, 4'b0001, 4'b0000);
    tick(10);
    check_level("t2_held", 4'b0001);
    b_n[0] = 1'b1;
    expect_ev(cyc + 7, 4'b0000, 4'b0001);
    tick(6);
    check_level("t2_before_release", 4'b0001);
    tick(1);
    check_level("t2_after_release", 4'b0000);
    tick(5);

    // Press bounce on channel 1
    b_n[1] = 1'b0;
    tick(3);
    b_n[1] = 1'b1;
    tick(1);
    b_n[1] = 1'b0;
    tick(3);
    b_n[1] = 1'b1;
    tick(10);
    check_level("t3_bounce", 4'b0000);

    // Release bounce on held channel 2
    b_n[2] = 1'b0;
    expect_ev(cyc + 7, 4'b0100, 4'b0000);
    tick(9);
    check_level("t4_held", 4'b0100);
    b_n[2] = 1'b1;
    tick(2);
    b_n[2] = 1'b0;
    tick(5);
    check_level("t4_after_bounce", 4'b0100);
    b_n[2] = 1'b1;
    expect_ev(cyc + 7, 4'b0000, 4'b0100);
    tick(10);
    check_level("t4_released", 4'b0000);

    // Concurrent presses on channels 0 and 3
    b_n = 4'b0110;
    expect_ev(cyc + 7, 4'b1001, 4'b0000);
    tick(8);
    check_level("t5_held", 4'b1001);
    b_n = 4'b1111;
    expect_ev(cyc + 7, 4'b0000, 4'b1001);
    tick(10);
    check_level("t5_released", 4'b0000);

    // Reset mid-debounce aborts the press
    b_n[1] = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(2);
    check_level("t5_in_reset", 4'b0000);
    b_n[1] = 1'b1;
    rst = 1'b0;
    tick(10);
    check_level("t5_after_abort", 4'b0000);

    // Long hold on channel 2: auto-repeat only when the feature is built in
    b_n[2] = 1'b0;
    a = cyc + 7;
    expect_ev(a, 4'b0100, 4'b0000);
`ifdef BTN_REPEAT_EN
    expect_ev(a + 20, 4'b0100, 4'b0000);
    expect_ev(a + 25, 4'b0100, 4'b0000);
    expect_ev(a + 30, 4'b0100, 4'b0000);
    expect_ev(a + 35, 4'b0100, 4'b0000);
`endif
    tick(44);
    check_level("t6_held", 4'b0100);
    b_n[2] = 1'b1;
    expect_ev(cyc + 7, 4'b0000, 4'b0100);
    tick(10);
    check_level("t6_released", 4'b0000);

    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d left in queue, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
